mac_norm_pack: RTL

Parametrised final stage of the FloatSD MAC pipeline. It takes the aligned, summed magnitude and exponent terms from the accumulate stage and produces one packed floating-point result per accepted input. Each result is normalised (leading-one detect), rounded, range-checked (saturate or flush) and packed as {sign, exponent, mantissa}. Compared with the fixed 16-bit stage it replaces, it adds generic field widths, valid/ready backpressure in place of an inhibit signal, and per-result overflow/underflow flags.

---
 rtl/mac_norm_pack_if.sv | 33 +++
 rtl/mac_norm_pack.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mac_norm_pack_if.sv
// Handshake and data bundle for the mac_norm_pack stage: upstream valid/ready
// with the accumulate-stage fields, downstream valid/ready with the packed result.
interface mac_norm_pack_if #(
    parameter int SUM_W  = 11,
    parameter int EXP_W  = 6,
    parameter int DIFF_W = 5,
    parameter int MAN_W  = 9
);
    localparam int OUT_W = 1 + EXP_W + MAN_W;

    logic              i_valid;
    logic              o_ready;
    logic              i_sgn;
    logic [EXP_W-1:0]  i_max_exp;
    logic [SUM_W-1:0]  i_norm_sum;
    logic [DIFF_W-1:0] i_exp_diff;
    logic              i_exp_carry;
    logic              o_valid;
    logic              i_ready;
    logic [OUT_W-1:0]  o_data;
    logic              o_ovf;
    logic              o_unf;

    modport master (
        output i_valid, i_sgn, i_max_exp, i_norm_sum, i_exp_diff, i_exp_carry, i_ready,
        input  o_ready, o_valid, o_data, o_ovf, o_unf
    );

    modport slave (
        input  i_valid, i_sgn, i_max_exp, i_norm_sum, i_exp_diff, i_exp_carry, i_ready,
        output o_ready, o_valid, o_data, o_ovf, o_unf
    );
endinterface

// File: rtl/mac_norm_pack.sv
// Final FloatSD MAC stage: normalise, round, range-check and pack one float per input.
// Build option MAC_NORM_RNE_EN: round-to-nearest-even when defined, truncation otherwise.
module mac_norm_pack #(
    parameter int SUM_W  = 11,
    parameter int EXP_W  = 6,
    parameter int DIFF_W = 5,
    parameter int MAN_W  = 9
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mac_norm_pack_if.slave bus
);
    localparam int OUT_W = 1 + EXP_W + MAN_W;
    localparam int E_W   = ((EXP_W > DIFF_W) ? EXP_W : DIFF_W) + 3;
    localparam int LZ_W  = $clog2(SUM_W);
    localparam int FW    = SUM_W - 1;
    localparam int EXT_W = FW + MAN_W + 2;
    localparam logic signed [E_W-1:0] E_MAX = {{(E_W-EXP_W){1'b0}}, {EXP_W{1'b1}}};

    logic              en_a_s;
    logic              en_b_s;

    logic              va_r;
    logic              sgn_a_r;
    logic [EXP_W-1:0]  max_exp_a_r;
    logic [SUM_W-1:0]  sum_a_r;
    logic [DIFF_W-1:0] diff_a_r;
    logic              carry_a_r;

    logic              vb_r;
    logic [OUT_W-1:0]  data_b_r;
    logic              ovf_b_r;
    logic              unf_b_r;

    logic [LZ_W-1:0]      lz_s;
    logic signed [E_W-1:0] e_s;
    logic [SUM_W-1:0]     shifted_s;
    logic [FW-1:0]        frac_s;
    logic [EXT_W-1:0]     ext_s;
    logic [MAN_W-1:0]     man_s;
    logic [MAN_W-1:0]     man_rnd_s;
    logic signed [E_W-1:0] e_rnd_s;
    logic                 unused_hidden_s;
    logic [OUT_W-1:0]     data_nxt_s;
    logic                 ovf_nxt_s;
    logic                 unf_nxt_s;

    // The output stage advances whenever it is empty or drained; stage A behind it.
    assign en_b_s      = ~vb_r | bus.i_ready;
    assign en_a_s      = ~va_r | en_b_s;
    assign bus.o_ready = en_a_s;

    // Stage A: capture accepted input fields.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            va_r        <= 1'b0;
            sgn_a_r     <= 1'b0;
            max_exp_a_r <= {EXP_W{1'b0}};
            sum_a_r     <= {SUM_W{1'b0}};
            diff_a_r    <= {DIFF_W{1'b0}};
            carry_a_r   <= 1'b0;
        end else begin
            if (en_a_s) begin
                va_r <= bus.i_valid;
            end
            if (en_a_s && bus.i_valid) begin
                sgn_a_r     <= bus.i_sgn;
                max_exp_a_r <= bus.i_max_exp;
                sum_a_r     <= bus.i_norm_sum;
                diff_a_r    <= bus.i_exp_diff;
                carry_a_r   <= bus.i_exp_carry;
            end
        end
    end

    // Leading-one detect: the highest set bit wins, so scan upward.
    always_comb begin
        lz_s = {LZ_W{1'b0}};
        for (int i = 0; i < SUM_W; i++) begin
            lz_s = sum_a_r[i] ? LZ_W'(SUM_W - 1 - i) : lz_s;
        end
    end

    assign e_s = $signed({{(E_W-EXP_W){1'b0}}, max_exp_a_r})
               + $signed({{(E_W-DIFF_W){diff_a_r[DIFF_W-1]}}, diff_a_r})
               + $signed({{(E_W-1){1'b0}}, carry_a_r})
               - $signed({{(E_W-LZ_W){1'b0}}, lz_s});

    // Normalise; the hidden leading one is dropped, and padding covers narrow sums.
    assign shifted_s       = sum_a_r << lz_s;
    assign frac_s          = shifted_s[FW-1:0];
    assign unused_hidden_s = shifted_s[SUM_W-1];
    assign ext_s           = {frac_s, {(MAN_W+2){1'b0}}};
    assign man_s           = ext_s[EXT_W-1 -: MAN_W];

`ifdef MAC_NORM_RNE_EN
    logic                 rbit_s;
    logic                 sticky_s;
    logic                 round_up_s;
    logic                 man_carry_s;
    logic [MAN_W-1:0]     man_inc_s;

    assign rbit_s     = ext_s[EXT_W-1-MAN_W];
    assign sticky_s   = |ext_s[EXT_W-2-MAN_W:0];
    assign round_up_s = rbit_s & (sticky_s | man_s[0]);
    assign {man_carry_s, man_inc_s} = {1'b0, man_s} + {{MAN_W{1'b0}}, 1'b1};

    // Round to nearest-even; a mantissa carry leaves M at zero and bumps the exponent.
    always_comb begin
        man_rnd_s = man_s;
        e_rnd_s   = e_s;
        if (round_up_s) begin
            man_rnd_s = man_inc_s;
            e_rnd_s   = e_s + $signed({{(E_W-1){1'b0}}, man_carry_s});
        end else begin
            man_rnd_s = man_s;
            e_rnd_s   = e_s;
        end
    end
`else
    logic unused_round_bits_s;

    assign unused_round_bits_s = ^ext_s[EXT_W-1-MAN_W:0];
    assign man_rnd_s           = man_s;
    assign e_rnd_s             = e_s;
`endif

    // Range check in priority order: zero, overflow (saturate), underflow (flush), normal.
    always_comb begin
        data_nxt_s = {OUT_W{1'b0}};
        ovf_nxt_s  = 1'b0;
        unf_nxt_s  = 1'b0;
        if (sum_a_r == {SUM_W{1'b0}}) begin
            data_nxt_s = {OUT_W{1'b0}};
        end else if (e_rnd_s > E_MAX) begin
            data_nxt_s = {sgn_a_r, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            ovf_nxt_s  = 1'b1;
        end else if (e_rnd_s <= $signed({E_W{1'b0}})) begin
            data_nxt_s = {OUT_W{1'b0}};
            unf_nxt_s  = 1'b1;
        end else begin
            data_nxt_s = {sgn_a_r, e_rnd_s[EXP_W-1:0], man_rnd_s};
        end
    end

    // Stage B: registered result, held while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vb_r     <= 1'b0;
            data_b_r <= {OUT_W{1'b0}};
            ovf_b_r  <= 1'b0;
            unf_b_r  <= 1'b0;
        end else begin
            if (en_b_s) begin
                vb_r <= va_r;
            end
            if (en_b_s && va_r) begin
                data_b_r <= data_nxt_s;
                ovf_b_r  <= ovf_nxt_s;
                unf_b_r  <= unf_nxt_s;
            end
        end
    end

    assign bus.o_valid = vb_r;
    assign bus.o_data  = data_b_r;
    assign bus.o_ovf   = ovf_b_r;
    assign bus.o_unf   = unf_b_r;
endmodule
